cpu_boot_loader: RTL and testbench

//  Sequences program/data image loading into the CPU before execution. Consumes a

---
 rtl/cpu_boot_loader_if.sv | 24 ++
 rtl/cpu_boot_loader.sv | 180 ++++++++++++++++++
 tb/tb_cpu_boot_loader.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_boot_loader_if.sv
// ---------------------------------------------------------------------------
// cpu_boot_loader_if
//   Word stream from the host/UART front-end into the boot loader.
//
//   Handshake: a word transfers on the rising clock edge where in_valid and
//   in_ready are both 1. The master holds in_data stable while in_valid is
//   high and the word has not yet transferred. in_ready does not depend on
//   in_valid.
//
//   Signals
//     in_valid  master -> slave  word on in_data is valid
//     in_ready  slave  -> master slave can accept a word this cycle
//     in_data   master -> slave  stream word (header, payload or checksum)
// ---------------------------------------------------------------------------
interface cpu_boot_loader_if #(
  parameter int DATA_W = 32
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/cpu_boot_loader.sv
// ---------------------------------------------------------------------------
// cpu_boot_loader
//   Loads program/data images into the CPU before it runs. Consumes a word
//   stream of headers and payload, drives the CPU load port and holds the CPU
//   in reset until a GO header releases it.
//
//   Optional feature macro: LOADER_CHECKSUM_EN
//     defined   -> each payload block is followed by one checksum word (sum of
//                  the payload words mod 2^DATA_W); a mismatch sets err.
//     undefined -> the last payload word returns straight to header decode.
//
//   Header word: [31:30] target (00 IMEM, 01 DMEM, 10 reserved, 11 GO)
//                [CNT_W+15:16] payload word count, [ADDR_W-1:0] start address
//
//   Ports
//     clk, rst           clock, synchronous active-high reset
//     s_in               stream slave (in_valid/in_ready/in_data)
//     cpu_rst            1 = CPU held in reset
//     address            CPU load-port address
//     inst_data          CPU load-port write data
//     write_instruction  one-cycle instruction-memory write strobe
//     write_data         one-cycle data-memory write strobe
//     busy               1 while loading payload or checksum
//     err                sticky error, cleared only by rst
//     state_dbg          current FSM state (S_RST=0 HDR=1 LOAD=2 CHK=3 RUN=4)
// ---------------------------------------------------------------------------
module cpu_boot_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 10
) (
  input  logic                clk,
  input  logic                rst,
  cpu_boot_loader_if.slave    s_in,
  output logic                cpu_rst,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W-1:0]   inst_data,
  output logic                write_instruction,
  output logic                write_data,
  output logic                busy,
  output logic                err,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    S_RST  = 3'd0,  // one cycle after reset release, stream not yet accepted
    S_HDR  = 3'd1,
    S_LOAD = 3'd2,
    S_CHK  = 3'd3,
    S_RUN  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic              accept;
  logic [1:0]        hdr_tgt;
  logic [CNT_W-1:0]  hdr_cnt;
  logic [ADDR_W-1:0] hdr_addr;
  logic              tgt_dmem;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] cur;
  logic              last_word;

  assign accept    = s_in.in_valid & s_in.in_ready;
  assign hdr_tgt   = s_in.in_data[DATA_W-1:DATA_W-2];
  assign hdr_cnt   = s_in.in_data[CNT_W+15:16];
  assign hdr_addr  = s_in.in_data[ADDR_W-1:0];
  assign last_word = (cnt == CNT_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_RST;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_RST: state_nxt = S_HDR;
      S_HDR: begin
        if (accept) begin
          case (hdr_tgt)
            2'b00, 2'b01: if (hdr_cnt != '0) state_nxt = S_LOAD;
            2'b11:        if (!err) state_nxt = S_RUN;
            default:      state_nxt = S_HDR;
          endcase
        end
      end
      S_LOAD: begin
        if (accept && last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = S_CHK;
`else
          state_nxt = S_HDR;
`endif
        end
      end
      S_CHK:   if (accept) state_nxt = S_HDR;
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_HDR;
    endcase
  end

  // Output logic (state-decoded)
  always_comb begin
    s_in.in_ready = 1'b0;
    busy          = 1'b0;
    cpu_rst       = 1'b1;
    state_dbg     = state;
    case (state)
      S_HDR:   s_in.in_ready = 1'b1;
      S_LOAD,
      S_CHK: begin
        s_in.in_ready = 1'b1;
        busy          = 1'b1;
      end
      S_RUN:   cpu_rst = 1'b0;
      default: ;
    endcase
  end

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
`endif

  // Datapath: header latch, load port and error flag.
  // Strobes are pulsed for exactly the cycle after each accepted payload word;
  // address/inst_data keep the last written value in between.
  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_dmem          <= 1'b0;
      cnt               <= '0;
      cur               <= '0;
      err               <= 1'b0;
      address           <= '0;
      inst_data         <= '0;
      write_instruction <= 1'b0;
      write_data        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum               <= '0;
`endif
    end else begin
      write_instruction <= 1'b0;
      write_data        <= 1'b0;
      if (accept) begin
        case (state)
          S_HDR: begin
            if (hdr_tgt == 2'b10) begin
              err <= 1'b1;
            end else if (!hdr_tgt[1]) begin
              tgt_dmem <= hdr_tgt[0];
              cnt      <= hdr_cnt;
              cur      <= hdr_addr;
`ifdef LOADER_CHECKSUM_EN
              sum      <= '0;
`endif
            end
          end
          S_LOAD: begin
            address           <= cur;
            inst_data         <= s_in.in_data;
            write_instruction <= ~tgt_dmem;
            write_data        <= tgt_dmem;
            cur               <= cur + ADDR_W'(1);  // wraps modulo 2^ADDR_W
            cnt               <= cnt - CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
            sum               <= sum + s_in.in_data;
`endif
          end
`ifdef LOADER_CHECKSUM_EN
          S_CHK: if (s_in.in_data != sum) err <= 1'b1;
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_boot_loader.sv
module tb_cpu_boot_loader;

  logic        clk;
  logic        rst;
  logic        cpu_rst;
  logic [9:0]  address;
  logic [31:0] inst_data;
  logic        write_instruction;
  logic        write_data;
  logic        busy;
  logic        err;
  logic [2:0]  state_dbg;

  cpu_boot_loader_if #(.DATA_W(32)) bus ();

  cpu_boot_loader dut (
    .clk               (clk),
    .rst               (rst),
    .s_in              (bus.slave),
    .cpu_rst           (cpu_rst),
    .address           (address),
    .inst_data         (inst_data),
    .write_instruction (write_instruction),
    .write_data        (write_data),
    .busy              (busy),
    .err               (err),
    .state_dbg         (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // expected strobe entries: {write_instruction, write_data, address, inst_data}
  logic [43:0] exp_q[$];

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (write_instruction && write_data)
      check_vec("both_strobes", 1, 0);
    if (write_instruction || write_data) begin
      if (exp_q.size() == 0) begin
        check_vec("unexp_strobe", {address, inst_data}, 0);
      end else begin
        check_vec("strobe", {write_instruction, write_data, address, inst_data}, exp_q.pop_front());
      end
    end else if (exp_q.size() != 0) begin
      check_vec("missing_strobe", 0, 1);
      void'(exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the word transferred.
  task automatic send_word(input logic [31:0] w, input bit wr, input bit imem,
                           input logic [9:0] a);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check_vec("ready_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (wr) exp_q.push_back({imem, ~imem, a, w});
    @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    check_vec("rst_cpu_rst",  cpu_rst, 1);
    check_vec("rst_in_ready", bus.in_ready, 0);
    check_vec("rst_outputs",  {address, inst_data, write_instruction, write_data, busy, err}, 0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_vec("post_rst_ready", bus.in_ready, 1);
    check_vec("post_rst_cpu_rst", cpu_rst, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    @(negedge clk);

    // 1: reset
    do_reset(3);
    idle(2);
    check_vec("idle_cpu_rst", cpu_rst, 1);

    // 2: IMEM load of 3 words at 0, back-to-back
    send_word(32'h0003_0000, 0, 0, 0);
    check_vec("load_busy", busy, 1);
    send_word(32'hDEAD_BEEF, 1, 1, 10'd0);
    send_word(32'h1234_5678, 1, 1, 10'd1);
    send_word(32'hCAFE_F00D, 1, 1, 10'd2);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'hDEAD_BEEF + 32'h1234_5678 + 32'hCAFE_F00D, 0, 0, 0);
`endif
    check_vec("imem_cpu_rst", cpu_rst, 1);
    check_vec("imem_last_addr", address, 10'd2);

    // 3: DMEM load at 15, then GO
    send_word(32'h4002_000F, 0, 0, 0);
    send_word(32'h0000_000A, 1, 0, 10'd15);
    send_word(32'h0000_0005, 1, 0, 10'd16);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'h0000_000F, 0, 0, 0);
`endif
    idle(1);
    check_vec("hold_data", {address, inst_data}, {10'd16, 32'h0000_0005});
    send_word(32'hC000_0000, 0, 0, 0);
    check_vec("go_cpu_rst", cpu_rst, 0);
    check_vec("go_in_ready", bus.in_ready, 0);
    idle(3);
    check_vec("run_in_ready", bus.in_ready, 0);
    check_vec("run_cpu_rst", cpu_rst, 0);

    // 4: address wrap, reserved target, GO ignored
    do_reset(2);
    send_word(32'h0002_03FF, 0, 0, 0);
    send_word(32'h1111_2222, 1, 1, 10'd1023);
    send_word(32'h3333_4444, 1, 1, 10'd0);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'h1111_2222 + 32'h3333_4444, 0, 0, 0);
`endif
    send_word(32'h8000_0000, 0, 0, 0);
    check_vec("rsvd_err", err, 1);
    send_word(32'hC000_0000, 0, 0, 0);
    idle(1);
    check_vec("go_ignored_cpu_rst", cpu_rst, 1);
    check_vec("go_ignored_ready", bus.in_ready, 1);

    // zero-count header: no writes, stays in header decode
    send_word(32'h0000_0005, 0, 0, 0);
    check_vec("zero_cnt_busy", busy, 0);

    // 5: reset after 1 of 3 payload words
    send_word(32'h4003_0100, 0, 0, 0);
    send_word(32'hAAAA_5555, 1, 0, 10'h100);
    idle(0);
    do_reset(2);
    idle(3);
    check_vec("abort_outputs", {address, inst_data, busy, err}, 0);

`ifdef LOADER_CHECKSUM_EN
    // 6: checksum match then mismatch
    send_word(32'h0002_0000, 0, 0, 0);
    send_word(32'h0000_0010, 1, 1, 10'd0);
    send_word(32'h0000_0020, 1, 1, 10'd1);
    check_vec("chk_busy", busy, 1);
    send_word(32'h0000_0030, 0, 0, 0);
    check_vec("chk_ok_err", err, 0);
    send_word(32'hC000_0000, 0, 0, 0);
    check_vec("chk_ok_go", cpu_rst, 0);
    do_reset(2);
    send_word(32'h0002_0000, 0, 0, 0);
    send_word(32'h0000_0010, 1, 1, 10'd0);
    send_word(32'h0000_0020, 1, 1, 10'd1);
    send_word(32'h0000_0031, 0, 0, 0);
    check_vec("chk_bad_err", err, 1);
    send_word(32'hC000_0000, 0, 0, 0);
    check_vec("chk_bad_go", cpu_rst, 1);
`endif

    idle(4);
    check_vec("sb_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
